// File: rtl/alu.sv
// Registered integer ALU: eight operations on two WIDTH-bit operands, one-cycle latency.
// Optional status flags (carry, overflow, negative) are compiled in with `define ALU_FLAGS_EN.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             overflow,
  output logic             negative
`endif
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } op_e;

  op_e              op;
  logic [SHW-1:0]   sh;
  logic             lt;
  logic [WIDTH-1:0] next_result;

  assign op = op_e'(alu_op);
  assign sh = operand2[SHW-1:0];
  assign lt = $signed(operand1) < $signed(operand2);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_result = '0;
    unique case (op)
      OP_ADD: next_result = operand1 + operand2;
      OP_SUB: next_result = operand1 - operand2;
      OP_AND: next_result = operand1 & operand2;
      OP_OR:  next_result = operand1 | operand2;
      OP_XOR: next_result = operand1 ^ operand2;
      OP_SLT: next_result = {{(WIDTH-1){1'b0}}, lt};
      OP_SLL: next_result = operand1 << sh;
      OP_SRL: next_result = operand1 >> sh;
      default: next_result = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic next_carry;
  logic next_overflow;

  // Carry-out of an add shows up as unsigned wrap; SUB carry means "no borrow".
  always_comb begin
    next_carry    = 1'b0;
    next_overflow = 1'b0;
    if (op == OP_ADD) begin
      next_carry    = next_result < operand1;
      next_overflow = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                      (next_result[WIDTH-1] != operand1[WIDTH-1]);
    end else if (op == OP_SUB) begin
      next_carry    = operand1 >= operand2;
      next_overflow = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                      (next_result[WIDTH-1] != operand1[WIDTH-1]);
    end
  end
`endif

  // NOTE: registers use non-blocking assignments so all outputs update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
`ifdef ALU_FLAGS_EN
      carry     <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result    <= next_result;
        zero      <= (next_result == '0);
`ifdef ALU_FLAGS_EN
        carry     <= next_carry;
        overflow  <= next_overflow;
        negative  <= next_result[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus randomized traffic
// compared against an arithmetic reference model (flags checked when ALU_FLAGS_EN is defined).
module tb_alu;

  localparam int WIDTH = 32;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SLT = 3'd5, SLL = 3'd6, SRL = 3'd7;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [2:0]       alu_op = '0;
  logic [WIDTH-1:0] operand1 = '0;
  logic [WIDTH-1:0] operand2 = '0;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
`ifdef ALU_FLAGS_EN
  logic             carry, overflow, negative;
`endif

  always #5 clk = ~clk;

  alu #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .alu_op(alu_op),
    .operand1(operand1),
    .operand2(operand2),
    .out_valid(out_valid),
    .result(result),
    .zero(zero)
`ifdef ALU_FLAGS_EN
    ,
    .carry(carry),
    .overflow(overflow),
    .negative(negative)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             ov;
  } ref_t;

  // Reference computed with wide integer arithmetic rather than bit tricks.
  function automatic ref_t ref_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
    ref_t            r;
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint          s;
    longint unsigned full;
    longint          smax = 64'sd2147483647;
    longint          smin = -64'sd2147483648;
    r.cy = 1'b0;
    r.ov = 1'b0;
    case (op)
      ADD: begin
        full  = ua + ub;
        r.res = full[WIDTH-1:0];
        r.cy  = full > 64'hFFFF_FFFF;
        s     = sa + sb;
        r.ov  = (s > smax) || (s < smin);
      end
      SUB: begin
        full  = ua - ub;
        r.res = full[WIDTH-1:0];
        r.cy  = ua >= ub;
        s     = sa - sb;
        r.ov  = (s > smax) || (s < smin);
      end
      AND_: r.res = a & b;
      OR_:  r.res = a | b;
      XOR_: r.res = a ^ b;
      SLT:  r.res = (sa < sb) ? 1 : 0;
      SLL:  r.res = a << (ub % WIDTH);
      default: r.res = a >> (ub % WIDTH);
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] exp_result = '0;
  logic             exp_zero   = 1'b1;
  logic             exp_valid  = 1'b0;
  logic             exp_cy     = 1'b0;
  logic             exp_ov     = 1'b0;
  logic             exp_neg    = 1'b0;

  task automatic step(input logic r, input logic v, input logic [2:0] op,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    ref_t m;
    rst      = r;
    in_valid = v;
    alu_op   = op;
    operand1 = a;
    operand2 = b;
    @(posedge clk);
    #1;
    if (r) begin
      exp_valid  = 1'b0;
      exp_result = '0;
      exp_zero   = 1'b1;
      exp_cy     = 1'b0;
      exp_ov     = 1'b0;
      exp_neg    = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        m          = ref_op(op, a, b);
        exp_result = m.res;
        exp_zero   = (m.res == 0);
        exp_cy     = m.cy;
        exp_ov     = m.ov;
        exp_neg    = m.res[WIDTH-1];
      end
    end
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("result", 64'(result), 64'(exp_result));
    check("zero", 64'(zero), 64'(exp_zero));
`ifdef ALU_FLAGS_EN
    check("carry", 64'(carry), 64'(exp_cy));
    check("overflow", 64'(overflow), 64'(exp_ov));
    check("negative", 64'(negative), 64'(exp_neg));
`endif
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    step(1, 0, ADD, 0, 0);
    check("reset_result", 64'(result), 64'h0);
    check("reset_zero", 64'(zero), 64'h1);
    check("reset_valid", 64'(out_valid), 64'h0);

    step(0, 1, ADD, 10, 10);
    check("add_10_10", 64'(result), 64'd20);
    step(0, 1, SUB, 10, 10);
    check("sub_eq_zero", 64'(zero), 64'h1);
    step(0, 1, SUB, 0, 1);
    check("sub_wrap", 64'(result), 64'hFFFF_FFFF);
    step(0, 1, SLT, 32'hFFFF_FFFF, 1);
    check("slt_neg", 64'(result), 64'h1);
    step(0, 1, SLT, 1, 32'hFFFF_FFFF);
    check("slt_pos", 64'(result), 64'h0);
    step(0, 1, SLL, 1, 31);
    check("sll_31", 64'(result), 64'h8000_0000);
    step(0, 1, SRL, 32'h8000_0000, 32'h21);
    check("srl_sh1", 64'(result), 64'h4000_0000);
    step(0, 1, SLL, 32'h1234_5678, 32'h40);
    check("sll_sh0", 64'(result), 64'h1234_5678);

    step(0, 1, ADD, 32'h7FFF_FFFF, 1);
`ifdef ALU_FLAGS_EN
    check("add_ovf_flag", 64'(overflow), 64'h1);
    check("add_ovf_carry", 64'(carry), 64'h0);
`endif
    step(0, 1, ADD, 32'hFFFF_FFFF, 1);
    check("add_carry_zero", 64'(zero), 64'h1);
`ifdef ALU_FLAGS_EN
    check("add_carry_flag", 64'(carry), 64'h1);
`endif
    step(0, 1, XOR_, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    step(0, 0, ADD, 1, 1);
    check("idle_hold", 64'(result), 64'hAAAA_AAAA);
    step(1, 1, ADD, 5, 5);
    check("rst_wins", 64'(result), 64'h0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), pick(), pick());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
